// File: rtl/seq_chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder_pkg
//   Shared declarations for the chunk-serial adder:
//     state_t    : FSM state encoding (IDLE, RUN, DONE)
//     nchunk()   : number of CHUNK-bit slices in a WIDTH-bit operand
//     idx_width(): bit width of a chunk index able to address nchunk slices
// ---------------------------------------------------------------------------
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_slice.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder_slice
//   Purely combinational CHUNK-bit ripple slice: {co, s} = x + y + ci.
//   Ports:
//     x, y : CHUNK-bit operand slices
//     ci   : carry into the slice
//     s    : CHUNK-bit slice sum
//     co   : carry out of the slice MSB
// ---------------------------------------------------------------------------
module seq_chunk_adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign s       = w_total[CHUNK-1:0];
  assign co      = w_total[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder that processes CHUNK bits per clock. Operands are
//   captured on an in_valid handshake in IDLE, summed one slice per cycle in
//   RUN, and the result is held in DONE until out_ready is seen.
//   Accept-to-out_valid latency is NCHUNK+1 cycles: NCHUNK slice cycles plus
//   one cycle that transfers the final carry into cout.
//
//   Optional feature macro: SEQ_CHUNK_ADDER_SUB_EN
//     When defined, an extra input 'sub' is captured with the operands and
//     sub=1 computes a - b as a + ~b + 1 (cin ignored; cout=1 means no borrow).
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : synchronous active-low reset
//     in_valid  : operands a, b, cin present
//     in_ready  : block idle and able to accept operands
//     a, b      : WIDTH-bit operands
//     cin       : carry-in
//     out_valid : sum / cout valid
//     out_ready : consumer accepts result
//     sum       : WIDTH-bit result (modulo 2^WIDTH)
//     cout      : carry out of bit WIDTH-1
//     sub       : (macro only) subtract select
// ---------------------------------------------------------------------------
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_fin;       // last slice done; next RUN cycle publishes cout
  logic               r_in_ready;
  logic               r_out_valid;
  logic [IDX_W-1:0]   r_idx;

  logic [CHUNK-1:0]   w_x;
  logic [CHUNK-1:0]   w_y;
  logic [CHUNK-1:0]   w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_sum_upd;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_x = r_a[i*CHUNK +: CHUNK];
        w_y = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  seq_chunk_adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .x  (w_x),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Merge the fresh slice result into the running sum; other slices keep
  // their current value.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_sum_upd
      assign w_sum_upd[gi*CHUNK +: CHUNK] =
        (r_idx == IDX_W'(gi)) ? w_s : r_sum[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_fin       <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            // Two's-complement subtract: invert b and force carry-in.
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
            r_idx      <= '0;
            r_fin      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          if (!r_fin) begin
            r_sum   <= w_sum_upd;
            r_carry <= w_co;
            if (r_idx == IDX_W'(NCHUNK - 1)) begin
              r_fin <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cout      <= r_carry;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Directed bench for seq_chunk_adder: a 16/4 instance driven from a vector
//   table plus hand-written backpressure and reset sequences, and an 8/8
//   instance for the single-slice configuration.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit chunk instance
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        sub;

  // 8-bit, 8-bit chunk instance
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  sum8;
  logic        cout8;
  logic        sub8;

  int n_cmp = 0;
  int n_err = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    ,
    .sub       (sub)
`endif
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    ,
    .sub       (sub8)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the 16-bit instance.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_b, input logic tcin,
                       input logic tsub, input logic [15:0] es, input logic eco,
                       input string nm);
    int t;
    int lat;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = ~tsub;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd5);
    chk({nm, ".sum"},     32'(sum), 32'(es));
    chk({nm, ".cout"},    32'(cout), 32'(eco));
    $display("op16 %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d (exp %h/%b/5)",
             nm, ta, tb_b, tcin, tsub, sum, cout, lat, es, eco);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".out_valid_after_hs"}, 32'(out_valid), 32'd0);
  endtask

  // One complete transaction on the 8-bit single-slice instance.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_b, input logic tcin,
                      input logic [7:0] es, input logic eco, input string nm);
    int t;
    int lat;
    t = 0;
    while (!in_ready8 && t < 50) begin
      tick();
      t++;
    end
    chk({nm, ".in_ready"}, 32'(in_ready8), 32'd1);
    a8 = ta; b8 = tb_b; cin8 = tcin; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd2);
    chk({nm, ".sum"},     32'(sum8), 32'(es));
    chk({nm, ".cout"},    32'(cout8), 32'(eco));
    $display("op8 %s a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d (exp %h/%b/2)",
             nm, ta, tb_b, tcin, sum8, cout8, lat, es, eco);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    chk({nm, ".out_valid_after_hs"}, 32'(out_valid8), 32'd0);
  endtask

  initial begin
    int t;
    int lat;
    int stray;

    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset.in_ready",   32'(in_ready),   32'd1);
    chk("reset.out_valid",  32'(out_valid),  32'd0);
    chk("reset.sum",        32'(sum),        32'd0);
    chk("reset.cout",       32'(cout),       32'd0);
    chk("reset8.in_ready",  32'(in_ready8),  32'd1);
    chk("reset8.out_valid", 32'(out_valid8), 32'd0);

    // Table-driven additions
    for (int i = 0; i < 8; i++) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].co,
            $sformatf("vec%0d", i));
    end

    // Backpressure: result held while new operands are offered
    run16(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "bp_warm");
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
    chk("bp.first_latency", 32'(t), 32'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'hA000 + 16'(i);
      b = 16'h0F0F;
      cin = i[1];
      tick();
      chk($sformatf("bp.hold%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp.hold%0d.sum", i),       32'(sum),       32'h2345);
      chk($sformatf("bp.hold%0d.in_ready", i),  32'(in_ready),  32'd0);
    end
    $display("bp held result sum=%h cout=%b for 10 cycles", sum, cout);
    a = 16'h1000; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.hs.out_valid", 32'(out_valid), 32'd0);
    chk("bp.hs.in_ready",  32'(in_ready),  32'd1);
    chk("bp.hs.sum_kept",  32'(sum),       32'h2345);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp.second.latency", 32'(lat),  32'd5);
    chk("bp.second.sum",     32'(sum),  32'h1001);
    chk("bp.second.cout",    32'(cout), 32'd0);
    $display("bp second op a=1000 b=0001 -> sum=%h cout=%b lat=%0d", sum, cout, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the third RUN cycle
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid.in_ready",  32'(in_ready),  32'd1);
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.sum",       32'(sum),       32'd0);
    chk("rst_mid.cout",      32'(cout),      32'd0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stray++;
    end
    chk("rst_mid.no_stale", 32'(stray), 32'd0);
    $display("reset mid-RUN: in_ready=%b out_valid=%b sum=%h stray=%0d",
             in_ready, out_valid, sum, stray);
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, "post_rst");

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    run16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub0");
    run16(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub1");
`endif

    // Single-slice configuration
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "w8_0");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "w8_1");
    run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "w8_2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0 required, otherwise elaboration error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  sum/cout valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE with in_valid=1, register a, b, cin, clear the chunk index to 0, and go to RUN.
REQ-017 SHALL, in RUN, add chunk k of a and b plus the carry register each cycle, write CHUNK result bits into sum[k*CHUNK +: CHUNK], and latch carry-out into the carry register.
REQ-018 SHALL, after the chunk with index NCHUNK-1 (NCHUNK=WIDTH/CHUNK), go to DONE with cout set to the final carry; accept-to-out_valid latency is exactly NCHUNK+1 cycles.
REQ-019 SHALL, in DONE, hold out_valid=1 with sum and cout stable until out_ready=1; the cycle with out_valid&&out_ready returns to IDLE.
REQ-020 SHALL ignore in_valid and input changes outside IDLE; captured operands are not disturbed.
REQ-021 SHALL, with CHUNK==WIDTH, complete in one RUN cycle (latency 2).
REQ-022 SHALL wrap modulo 2^WIDTH; overflow is reported only through cout.
REQ-023 SHALL keep sum unchanged in IDLE after a handshake; sum is valid only while out_valid=1.

Reset
REQ-024 SHALL, on a clk edge with rst_n=0 in any state, go to IDLE, clear sum, cout, carry and chunk index to 0, and force out_valid=0; in_ready=1 the cycle after rst_n returns high.
REQ-025 SHALL discard an operation interrupted by reset mid-RUN or in DONE; no out_valid is produced for it.

Configuration
REQ-026 SHALL support macro SEQ_CHUNK_ADDER_SUB_EN: when defined, add input port sub (1 bit, captured with operands); sub=1 computes a - b as a + ~b + 1 (cin ignored), with cout=1 meaning no borrow.
REQ-027 SHALL, without SEQ_CHUNK_ADDER_SUB_EN, have no sub port and always compute a + b + cin.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, RUN, DONE) and an NCHUNK helper function in package seq_chunk_adder_pkg.
REQ-029 SHALL put the per-cycle adder in combinational sub-module seq_chunk_adder_slice (parameter CHUNK; inputs x, y, ci; outputs s, co).

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-030 SHALL check a=0x0001, b=0x0002, cin=0 -> sum=0x0003, cout=0, out_valid exactly 5 cycles after the accept edge.
REQ-031 SHALL check a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0 (carry across a chunk boundary).
REQ-032 SHALL check backpressure: out_ready=0 for 10 cycles while in_valid toggles with new operands -> out_valid held, sum stable, in_ready=0, second operand not accepted until the handshake completes.
REQ-033 SHALL check reset: rst_n=0 for one cycle in the 3rd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, no stale result later.
REQ-034 SHALL check, with SEQ_CHUNK_ADDER_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-035 SHALL check WIDTH=8, CHUNK=8: a=0x80, b=0x80 -> sum=0x00, cout=1, latency 2 cycles.
